alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: DW, 16, datapath width of operands and result.
REQ-002 Parameter: OPW, 4, opcode width.
REQ-003 Parameter: FLAG_OWNER, 0, the requester index whose operations update the ALU Z/V/N flags.
REQ-004 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: req0_valid / req1_valid  in  1  requester k presents an operation.
REQ-007 Ports: req0_op / req1_op  in  OPW  opcode for the ALU.
REQ-008 Ports: req0_a, req0_b / req1_a, req1_b  in  DW  operands, driven to alu_in1 and alu_in2 respectively.
REQ-009 Ports: req0_ready / req1_ready  out  1  grant; the operation transfers when valid and ready are both high at a clock edge.
REQ-010 Ports: alu_in1, alu_in2  out  DW; alu_opcode  out  OPW; alu_inval  out  1  drive the shared ALU.
REQ-011 Port: alu_result  in  DW  combinational ALU output for the current alu_* drive.
REQ-012 Ports: rsp0_valid / rsp1_valid  out  1; rsp0_data / rsp1_data  out  DW  per-requester result slots.
REQ-013 Ports: rsp0_ready / rsp1_ready  in  1  requester k consumes its result slot.

Function
REQ-014 Pipeline: grant edge N latches op, a, b and requester id into the issue stage (S1); during cycle N+1, S1 drives alu_*; edge N+1 captures alu_result into the owning rsp slot; rspk_valid is high from cycle N+2.
REQ-015 When S1 is empty, alu_in1, alu_in2 and alu_opcode hold their last values, and alu_inval is 0.
REQ-016 alu_inval is 1 exactly in cycles where S1 is valid and the S1 requester id equals FLAG_OWNER.
REQ-017 Requester k is eligible when S1 does not hold an op for k and (rspk_valid is 0 or rspk_ready is 1 in the same cycle).
REQ-018 reqk_ready is 1 only if requester k is eligible and the arbiter selects it; at most one ready is high per cycle.
REQ-019 Arbitration: the sole valid eligible requester is selected; if both are valid and eligible, the requester not granted most recently is selected.
REQ-020 The round-robin pointer updates only on an actual transfer; an idle cycle leaves it unchanged.
REQ-021 reqk_ready is combinational from req*_valid, S1 state and rsp slot state; it does not depend on reqk_op or reqk_a/b.
REQ-022 rspk_data and rspk_valid hold stable while rspk_valid=1 and rspk_ready=0.
REQ-023 Consume and fill of the same slot at one edge: the new result is loaded and rspk_valid stays 1.
REQ-024 Throughput: at most one transfer per cycle overall; one requester alone sustains one transfer per 2 cycles with rspk_ready held at 1.
REQ-025 No width conversion: operands and result pass unmodified at DW bits; the arbiter never interprets opcodes.

Reset
REQ-026 rst asserted: S1 valid=0, rsp0_valid=rsp1_valid=0, req0_ready=req1_ready=0, alu_inval=0, alu_in1=alu_in2=0, alu_opcode=0, rsp data=0, pointer favours requester 0.
REQ-027 Reset mid-operation discards any in-flight S1 op and any unconsumed result, and no flag update is issued for it.

Structure
REQ-028 Shared package wisc_pkg: DW, OPW, opcode constants (ADD=4'b0000, SUB=4'b0001, LLB=4'b1010, LHB=4'b1011) and a 1-bit requester-id type.
REQ-029 One sub-module, rr_arb2: two-way round-robin picker (inputs: two request bits and a transfer strobe; outputs: one-hot grant; contains the pointer register).

Verification
REQ-030 Single op: req0 ADD a=16'h0003 b=16'h0004 at edge 1 -> alu_opcode=0000, alu_inval=1 in cycle 2; rsp0_valid=1, rsp0_data=16'h0007 in cycle 3.
REQ-031 Contention: both valid at every edge from edge 1 -> grants alternate req0, req1, req0, req1; alu_inval=1 only in cycles where S1 holds a req0 op.
REQ-032 Backpressure: rsp1_ready=0 with rsp1_valid=1 and req1_valid=1 -> req1_ready stays 0 and rsp1_data stays stable; req0 is still granted; raising rsp1_ready re-enables the req1 grant in the same cycle.
REQ-033 Single requester streaming: req1 only, rsp1_ready=1, 6 ops -> ready pulses every 2nd cycle; 6 results arrive in order.
REQ-034 Reset mid-op: assert rst in the cycle S1 holds a req0 SUB -> alu_inval drops to 0 immediately, and no rsp0_valid follows; after release, the first contended grant goes to req0.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU front end: widths, opcodes and
// the requester-id type used by the issue stage.
package wisc_pkg;

  localparam int DW  = 16;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB = 4'b0001;
  localparam logic [OPW-1:0] OP_LLB = 4'b1010;
  localparam logic [OPW-1:0] OP_LHB = 4'b1011;

  typedef logic req_id_t;

  // One-hot grant to requester index; grant 2'b00 maps to requester 0.
  function automatic req_id_t onehot_id(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of requester handshakes, result slots and shared-ALU drive signals.
// Handshake: a transfer happens at a rising edge where valid and ready are both high.
interface alu_share_arb_if #(
  parameter int DW  = wisc_pkg::DW,
  parameter int OPW = wisc_pkg::OPW
);

  logic           req0_valid;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic           req0_ready;

  logic           req1_valid;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic           req1_ready;

  logic [DW-1:0]  alu_in1;
  logic [DW-1:0]  alu_in2;
  logic [OPW-1:0] alu_opcode;
  logic           alu_inval;
  logic [DW-1:0]  alu_result;

  logic           rsp0_valid;
  logic [DW-1:0]  rsp0_data;
  logic           rsp0_ready;

  logic           rsp1_valid;
  logic [DW-1:0]  rsp1_data;
  logic           rsp1_ready;

  // Environment side: requesters, result consumers and the ALU itself.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_opcode, alu_inval,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_opcode, alu_inval,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin picker; the priority bit moves only when a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       xfer_i,
  output logic [1:0] gnt_o
);

  // prio_q = 0 favours requester 0 on a tie, 1 favours requester 1.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    if (xfer_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters: a one-entry issue stage
// drives the ALU, and each requester owns a one-entry result slot.
module alu_share_arb
  import wisc_pkg::*;
#(
  parameter int DW         = wisc_pkg::DW,
  parameter int OPW        = wisc_pkg::OPW,
  parameter int FLAG_OWNER = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arb_if.slave       bus
);

  localparam req_id_t OWNER_ID = req_id_t'(FLAG_OWNER);

  logic           s1_valid_q, s1_valid_d;
  req_id_t        s1_id_q,    s1_id_d;
  logic [OPW-1:0] s1_op_q,    s1_op_d;
  logic [DW-1:0]  s1_a_q,     s1_a_d;
  logic [DW-1:0]  s1_b_q,     s1_b_d;

  logic [1:0]     rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_data_q [2];
  logic [DW-1:0]  rsp_data_d [2];

  logic [1:0]     req_valid;
  logic [1:0]     rsp_ready;
  logic [1:0]     s1_holds;
  logic [1:0]     eligible;
  logic [1:0]     arb_req;
  logic [1:0]     gnt;
  logic           xfer;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // s1_holds doubles as the slot-fill strobe: the op in S1 always lands next edge.
  assign s1_holds[0] = s1_valid_q && (s1_id_q == 1'b0);
  assign s1_holds[1] = s1_valid_q && (s1_id_q == 1'b1);

  // A requester may issue only if its slot is free by the time its op reaches it.
  assign eligible = ~s1_holds & (~rsp_valid_q | rsp_ready);
  assign arb_req  = req_valid & eligible & {2{~rst}};
  assign xfer     = |gnt;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req_i  (arb_req),
    .xfer_i (xfer),
    .gnt_o  (gnt)
  );

  always_comb begin
    s1_valid_d = xfer;
    s1_id_d    = s1_id_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (xfer) begin
      s1_id_d = onehot_id(gnt);
      if (gnt[1]) begin
        s1_op_d = bus.req1_op;
        s1_a_d  = bus.req1_a;
        s1_b_d  = bus.req1_b;
      end else begin
        s1_op_d = bus.req0_op;
        s1_a_d  = bus.req0_a;
        s1_b_d  = bus.req0_b;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rsp_valid_d[k] = s1_holds[k] | (rsp_valid_q[k] & ~rsp_ready[k]);
      rsp_data_d[k]  = s1_holds[k] ? bus.alu_result : rsp_data_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 2'b00;
      rsp_data_q[0] <= '0;
      rsp_data_q[1] <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q[0] <= rsp_data_d[0];
      rsp_data_q[1] <= rsp_data_d[1];
    end
  end

  // ALU operands keep their last values while S1 is empty; only inval qualifies them.
  assign bus.alu_in1    = s1_a_q;
  assign bus.alu_in2    = s1_b_q;
  assign bus.alu_opcode = s1_op_q;
  assign bus.alu_inval  = s1_valid_q && (s1_id_q == OWNER_ID);

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp0_data  = rsp_data_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp1_data  = rsp_data_q[1];

  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(bus.req0_ready && bus.req1_ready));

  a_no_slot_overwrite: assert property (@(posedge clk) disable iff (rst)
    (s1_holds & rsp_valid_q & ~rsp_ready) == 2'b00);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural model of the shared ALU.
module tb_alu_share_arb;
  import wisc_pkg::*;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] st_a   [6];
  logic [15:0] st_b   [6];
  logic [3:0]  st_op  [6];
  logic [15:0] st_exp [6];
  int          idx;
  int          got;
  int          extra;

  alu_share_arb_if #(.DW(16), .OPW(4)) bus ();

  alu_share_arb #(.DW(16), .OPW(4), .FLAG_OWNER(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: WISC-style ADD/SUB and byte loads (a is the destination value).
  always_comb begin
    case (bus.alu_opcode)
      OP_ADD:  bus.alu_result = bus.alu_in1 + bus.alu_in2;
      OP_SUB:  bus.alu_result = bus.alu_in1 - bus.alu_in2;
      OP_LLB:  bus.alu_result = {bus.alu_in1[15:8], bus.alu_in2[7:0]};
      OP_LHB:  bus.alu_result = {bus.alu_in2[7:0], bus.alu_in1[7:0]};
      default: bus.alu_result = 16'h0000;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req0_valid = v;
    bus.req0_op    = op;
    bus.req0_a     = a;
    bus.req0_b     = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req1_valid = v;
    bus.req1_op    = op;
    bus.req1_a     = a;
    bus.req1_b     = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st_a   = '{16'h1111, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h1234, 16'h1234};
    st_b   = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h00AA, 16'h00AA};
    st_op  = '{OP_ADD,   OP_ADD,   OP_ADD,   OP_SUB,   OP_LLB,   OP_LHB};
    st_exp = '{16'h1112, 16'h0000, 16'h8000, 16'hFFFF, 16'h12AA, 16'hAA34};

    // Reset state, with both requesters asking to prove ready is held low.
    rst = 1'b1;
    drive0(1'b1, OP_ADD, 16'h0000, 16'h0000);
    drive1(1'b1, OP_ADD, 16'h0000, 16'h0000);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_inval", bus.alu_inval, 0);
    chk("rst_alu_in1", bus.alu_in1, 0);
    chk("rst_alu_in2", bus.alu_in2, 0);
    chk("rst_opcode", bus.alu_opcode, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp0_data", bus.rsp0_data, 0);
    chk("rst_rsp1_data", bus.rsp1_data, 0);

    // Single op: req0 ADD 3+4.
    rst = 1'b0;
    drive1(1'b0, OP_ADD, 16'h0000, 16'h0000);
    drive0(1'b1, OP_ADD, 16'h0003, 16'h0004);
    #1;
    chk("single_ready", bus.req0_ready, 1);
    tick();
    drive0(1'b0, OP_ADD, 16'h0000, 16'h0000);
    chk("single_opcode", bus.alu_opcode, 4'b0000);
    chk("single_in1", bus.alu_in1, 16'h0003);
    chk("single_in2", bus.alu_in2, 16'h0004);
    chk("single_inval", bus.alu_inval, 1);
    chk("single_rsp_early", bus.rsp0_valid, 0);
    tick();
    chk("single_rsp_valid", bus.rsp0_valid, 1);
    chk("single_rsp_data", bus.rsp0_data, 16'h0007);
    chk("single_inval_off", bus.alu_inval, 0);
    chk("single_in1_hold", bus.alu_in1, 16'h0003);
    bus.rsp0_ready = 1'b1;
    tick();
    chk("single_consumed", bus.rsp0_valid, 0);

    // Contention: req0 was granted last, so req1 wins the first tie.
    bus.rsp1_ready = 1'b1;
    drive0(1'b1, OP_ADD, 16'h000A, 16'h0001);
    drive1(1'b1, OP_SUB, 16'h0014, 16'h0005);
    #1;
    chk("cont0_r1", bus.req1_ready, 1);
    chk("cont0_r0", bus.req0_ready, 0);
    tick();
    chk("cont1_r0", bus.req0_ready, 1);
    chk("cont1_r1", bus.req1_ready, 0);
    chk("cont1_inval", bus.alu_inval, 0);
    tick();
    chk("cont2_r1", bus.req1_ready, 1);
    chk("cont2_r0", bus.req0_ready, 0);
    chk("cont2_inval", bus.alu_inval, 1);
    chk("cont2_rsp1_valid", bus.rsp1_valid, 1);
    chk("cont2_rsp1_data", bus.rsp1_data, 16'h000F);
    tick();
    chk("cont3_r0", bus.req0_ready, 1);
    chk("cont3_r1", bus.req1_ready, 0);
    chk("cont3_inval", bus.alu_inval, 0);
    chk("cont3_rsp0_valid", bus.rsp0_valid, 1);
    chk("cont3_rsp0_data", bus.rsp0_data, 16'h000B);
    chk("cont3_rsp1_valid", bus.rsp1_valid, 0);
    tick();
    drive0(1'b0, OP_ADD, 16'h0000, 16'h0000);
    drive1(1'b0, OP_ADD, 16'h0000, 16'h0000);
    chk("cont4_inval", bus.alu_inval, 1);
    tick();
    tick();
    chk("drain_rsp0", bus.rsp0_valid, 0);
    chk("drain_rsp1", bus.rsp1_valid, 0);

    // Backpressure on slot 1.
    bus.rsp1_ready = 1'b0;
    drive1(1'b1, OP_LLB, 16'hAB12, 16'h0034);
    #1;
    chk("bp0_r1", bus.req1_ready, 1);
    tick();
    chk("bp1_r1", bus.req1_ready, 0);
    tick();
    drive1(1'b1, OP_LHB, 16'h00CD, 16'h00EF);
    drive0(1'b1, OP_ADD, 16'h0001, 16'h0002);
    #1;
    chk("bp2_rsp1_valid", bus.rsp1_valid, 1);
    chk("bp2_rsp1_data", bus.rsp1_data, 16'hAB34);
    chk("bp2_r1_blocked", bus.req1_ready, 0);
    chk("bp2_r0_granted", bus.req0_ready, 1);
    tick();
    drive0(1'b0, OP_ADD, 16'h0000, 16'h0000);
    #1;
    chk("bp3_r1_blocked", bus.req1_ready, 0);
    chk("bp3_rsp1_valid", bus.rsp1_valid, 1);
    chk("bp3_rsp1_stable", bus.rsp1_data, 16'hAB34);
    bus.rsp1_ready = 1'b1;
    #1;
    chk("bp3_r1_released", bus.req1_ready, 1);
    tick();
    drive1(1'b0, OP_ADD, 16'h0000, 16'h0000);
    chk("bp4_rsp1_valid", bus.rsp1_valid, 0);
    chk("bp4_rsp0_valid", bus.rsp0_valid, 1);
    chk("bp4_rsp0_data", bus.rsp0_data, 16'h0003);
    tick();
    chk("bp5_rsp1_valid", bus.rsp1_valid, 1);
    chk("bp5_rsp1_data", bus.rsp1_data, 16'hEFCD);
    tick();
    chk("bp6_idle", bus.rsp1_valid, 0);

    // Single-requester streaming on req1.
    idx   = 0;
    got   = 0;
    extra = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (bus.rsp1_valid) begin
        if (exp_q.size() > 0) begin
          chk("stream_data", bus.rsp1_data, exp_q.pop_front());
          got++;
        end else begin
          extra++;
        end
      end
      if (idx < 6) drive1(1'b1, st_op[idx], st_a[idx], st_b[idx]);
      else         drive1(1'b0, OP_ADD, 16'h0000, 16'h0000);
      #1;
      chk("stream_ready", bus.req1_ready, (idx < 6) && (cyc % 2 == 0));
      if (bus.req1_ready) begin
        exp_q.push_back(st_exp[idx]);
        idx++;
      end
      tick();
    end
    chk("stream_count", got, 6);
    chk("stream_extra", extra, 0);

    // Reset while S1 holds a req0 SUB; req0 was last granted beforehand.
    drive0(1'b1, OP_SUB, 16'h0005, 16'h0003);
    #1;
    chk("rmid_grant", bus.req0_ready, 1);
    tick();
    drive0(1'b0, OP_ADD, 16'h0000, 16'h0000);
    chk("rmid_inval", bus.alu_inval, 1);
    chk("rmid_opcode", bus.alu_opcode, 4'b0001);
    rst = 1'b1;
    #1;
    chk("rmid_inval_drop", bus.alu_inval, 0);
    chk("rmid_in1_clr", bus.alu_in1, 0);
    chk("rmid_opcode_clr", bus.alu_opcode, 0);
    tick();
    rst = 1'b0;
    chk("rmid_rsp0_a", bus.rsp0_valid, 0);
    tick();
    chk("rmid_rsp0_b", bus.rsp0_valid, 0);
    drive0(1'b1, OP_ADD, 16'h0002, 16'h0002);
    drive1(1'b1, OP_ADD, 16'h0003, 16'h0003);
    #1;
    chk("rpost_r0", bus.req0_ready, 1);
    chk("rpost_r1", bus.req1_ready, 0);
    tick();
    chk("rpost_next_r1", bus.req1_ready, 1);
    drive0(1'b0, OP_ADD, 16'h0000, 16'h0000);
    drive1(1'b0, OP_ADD, 16'h0000, 16'h0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
